sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_arbiter_if.sv | 19 +
 rtl/sram_arbiter_rr_pick.sv | 53 +++++
 rtl/sram_arbiter.sv | 117 +++++++++++
 tb/tb_sram_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, port index type and constants.
// No logic; imported by the arbiter, its picker and its client interface.
package sram_arb_pkg;

   localparam int NPORTS = 3;

   typedef logic [1:0] port_t;

   localparam port_t GRANT_NONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   function automatic port_t next_port(input port_t p);
      return (p >= 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Client side of the SRAM arbiter: level requests held until a one-cycle ack.
// master = requesters, slave = arbiter.
interface sram_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
) ();
   import sram_arb_pkg::*;

   logic [NPORTS-1:0]        req;
   logic [NPORTS-1:0]        wr;
   logic [NPORTS*ADDR_W-1:0] addr;
   logic [NPORTS*DATA_W-1:0] wdata;
   logic [NPORTS-1:0]        ack;
   logic [DATA_W-1:0]        rdata;

   modport master (output req, wr, addr, wdata, input ack, rdata);
   modport slave  (input req, wr, addr, wdata, output ack, rdata);

endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin winner select over three requests, starting after last.
// SRAM_ARB_VIDEO_PRIO_EN gives port 0 absolute priority; ports 1 and 2 rotate.
module rr_pick
   import sram_arb_pkg::*;
(
   input  logic [NPORTS-1:0] req,
   input  port_t             last,
   output port_t             winner,
   output logic              valid
);

`ifdef SRAM_ARB_VIDEO_PRIO_EN
   always_comb begin
      winner = GRANT_NONE;
      valid  = 1'b0;
      if (req[0]) begin
         winner = 2'd0;
         valid  = 1'b1;
      end else if (req[1] && req[2]) begin
         // last only ever records port 1 or 2 here, so it alone picks the turn
         winner = (last == 2'd1) ? 2'd2 : 2'd1;
         valid  = 1'b1;
      end else if (req[1]) begin
         winner = 2'd1;
         valid  = 1'b1;
      end else if (req[2]) begin
         winner = 2'd2;
         valid  = 1'b1;
      end
   end
`else
   port_t c0, c1, c2;

   always_comb begin
      c0     = next_port(last);
      c1     = next_port(c0);
      c2     = next_port(c1);
      winner = GRANT_NONE;
      valid  = 1'b0;
      if (req[c0]) begin
         winner = c0;
         valid  = 1'b1;
      end else if (req[c1]) begin
         winner = c1;
         valid  = 1'b1;
      end else if (req[c2]) begin
         winner = c2;
         valid  = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Three-client async SRAM sequencer: IDLE/SETUP/ACCESS/RECOVER, ack at T+2+WAIT_STATES after IDLE sample.
// Clients hold req until ack; optional SRAM_ARB_VIDEO_PRIO_EN gives port 0 absolute priority.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W      = 19,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   sram_arbiter_if.slave     bus,
   output port_t             grant_id,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_a,
   inout  wire  [DATA_W-1:0] sram_d,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   state_t              state, state_nxt;
   port_t               win;
   logic                win_vld;
   logic                latch_en;
   logic                ack_fire;
   logic                drive;
   logic [2:0]          cnt;
   port_t               last;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NPORTS-1:0]   ack_q;
   logic [DATA_W-1:0]   rdata_q;

   rr_pick u_pick (
      .req    (bus.req),
      .last   (last),
      .winner (win),
      .valid  (win_vld)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_en  = 1'b0;
      ack_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               latch_en  = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP:   state_nxt = ACCESS;
         ACCESS: begin
            if (cnt == 3'd0) begin
               ack_fire  = 1'b1;
               state_nxt = RECOVER;
            end
         end
         RECOVER: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id <= GRANT_NONE;
         last     <= 2'd2;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt      <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
      end else begin
         ack_q <= '0;
         if (latch_en) begin
            grant_id <= win;
            wr_q     <= bus.wr[win];
            addr_q   <= bus.addr[int'(win)*ADDR_W +: ADDR_W];
            wdata_q  <= bus.wdata[int'(win)*DATA_W +: DATA_W];
         end
         if (state == SETUP)
            cnt <= 3'(WAIT_STATES);
         else if (state == ACCESS && cnt != 3'd0)
            cnt <= cnt - 3'd1;
         if (ack_fire) begin
            ack_q[grant_id] <= 1'b1;
            if (!wr_q) rdata_q <= sram_d;
`ifdef SRAM_ARB_VIDEO_PRIO_EN
            if (grant_id != 2'd0) last <= grant_id;
`else
            last <= grant_id;
`endif
         end
         if (state == RECOVER) grant_id <= GRANT_NONE;
      end
   end

   // Data stays driven through RECOVER so the SRAM sees write hold time.
   assign drive     = (state != IDLE) && wr_q;
   assign sram_d    = drive ? wdata_q : {DATA_W{1'bz}};
   assign sram_a    = addr_q;
   assign sram_ce_n = 1'b0;
   assign sram_oe_n = drive;
   assign sram_we_n = !((state == ACCESS) && wr_q);
   assign busy      = (state != IDLE);
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench: dut_a runs WAIT_STATES=1, dut_b WAIT_STATES=0, each with a small SRAM model.
module tb_sram_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;

   typedef struct {
      logic [2:0] ack;
      logic       rd;
      logic [7:0] rdata;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_a, rst_b;
   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   logic [1:0]    grant_a, grant_b;
   logic          busy_a, busy_b, ce_a, ce_b, oe_a, oe_b, we_a, we_b;
   logic [AW-1:0] sa_a, sa_b;
   wire  [DW-1:0] sd_a, sd_b;
   logic [7:0]    mem_a [256];
   logic [7:0]    mem_b [256];

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1)) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a), .grant_id(grant_a), .busy(busy_a),
      .sram_a(sa_a), .sram_d(sd_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(we_a));

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b), .grant_id(grant_b), .busy(busy_b),
      .sram_a(sa_b), .sram_d(sd_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(we_b));

   always @(posedge clk) if (!ce_a && !we_a) mem_a[sa_a[7:0]] <= sd_a;
   always @(posedge clk) if (!ce_b && !we_b) mem_b[sa_b[7:0]] <= sd_b;
   assign sd_a = (!ce_a && !oe_a && we_a) ? mem_a[sa_a[7:0]] : 8'bz;
   assign sd_b = (!ce_b && !oe_b && we_b) ? mem_b[sa_b[7:0]] : 8'bz;

   int sel = 0;
   logic [2:0]    o_ack;
   logic [7:0]    o_rdata, o_d;
   logic [1:0]    o_grant;
   logic          o_busy, o_we, o_oe;
   logic [AW-1:0] o_a;
   assign o_ack   = (sel != 0) ? bus_b.ack   : bus_a.ack;
   assign o_rdata = (sel != 0) ? bus_b.rdata : bus_a.rdata;
   assign o_grant = (sel != 0) ? grant_b     : grant_a;
   assign o_busy  = (sel != 0) ? busy_b      : busy_a;
   assign o_we    = (sel != 0) ? we_b        : we_a;
   assign o_oe    = (sel != 0) ? oe_b        : oe_a;
   assign o_a     = (sel != 0) ? sa_b        : sa_a;
   assign o_d     = (sel != 0) ? sd_b        : sd_a;

   int n_cmp = 0;
   int n_err = 0;
   exp_t exp_q[$];
   int we_low, idle_cnt;
   logic hold_chk;
   logic [AW-1:0] exp_addr;
   logic [7:0] exp_wdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int port, input logic rd, input logic [7:0] rdv, input int at);
      exp_t e;
      e.ack   = 3'b001 << port;
      e.rd    = rd;
      e.rdata = rdv;
      e.cyc   = at;
      exp_q.push_back(e);
   endtask

   // Step until the selected DUT acks, then pop and compare the scoreboard head.
   task automatic wait_ack(input string tag, input int budget, input logic drop);
      exp_t e;
      logic got;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         tick();
         if (o_busy == 1'b0) idle_cnt++;
         if (o_we == 1'b0) begin
            we_low++;
            check({tag, "_we_addr"}, 32'(o_a), 32'(exp_addr));
            check({tag, "_we_data"}, 32'(o_d), 32'(exp_wdata));
         end
         if (o_ack != 3'b000) begin
            got = 1'b1;
            if (exp_q.size() == 0) begin
               check({tag, "_unexpected_ack"}, 32'(o_ack), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check({tag, "_ack"}, 32'(o_ack), 32'(e.ack));
               check({tag, "_ack_cycle"}, cyc, e.cyc);
               if (e.rd) check({tag, "_rdata"}, 32'(o_rdata), 32'(e.rdata));
               if (hold_chk) begin
                  check({tag, "_recover_we"}, 32'(o_we), 32'd1);
                  check({tag, "_recover_data"}, 32'(o_d), 32'(exp_wdata));
                  check({tag, "_recover_addr"}, 32'(o_a), 32'(exp_addr));
               end
               if (drop) begin
                  if (sel != 0) bus_b.req = bus_b.req & ~e.ack;
                  else          bus_a.req = bus_a.req & ~e.ack;
               end
            end
         end
      end
      check({tag, "_ack_seen"}, 32'(got), 32'd1);
   endtask

   initial begin
      int d, acks, busy_seen;
      int ord [6];
      logic [7:0] rdv [3];

      rst_a = 1'b1; rst_b = 1'b1; hold_chk = 1'b0;
      bus_a.req = '0; bus_a.wr = '0; bus_a.addr = '0; bus_a.wdata = '0;
      bus_b.req = '0; bus_b.wr = '0; bus_b.addr = '0; bus_b.wdata = '0;
      exp_addr = '0; exp_wdata = '0; we_low = 0; idle_cnt = 0;
      repeat (3) tick();

      check("rst_ack", 32'(bus_a.ack), 32'd0);
      check("rst_rdata", 32'(bus_a.rdata), 32'd0);
      check("rst_grant", 32'(grant_a), 32'd3);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_we_n", 32'(we_a), 32'd1);
      check("rst_oe_n", 32'(oe_a), 32'd0);
      check("rst_addr", 32'(sa_a), 32'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();

      // port 1 write, two cycles of we_n low, data held through RECOVER
      bus_a.addr[1*AW +: AW] = 19'h12345;
      bus_a.wdata[1*DW +: DW] = 8'hA5;
      bus_a.wr = 3'b010; bus_a.req = 3'b010;
      exp_addr = 19'h12345; exp_wdata = 8'hA5; hold_chk = 1'b1; we_low = 0;
      push_exp(1, 1'b0, 8'h00, cyc + 4);
      wait_ack("t1", 12, 1'b1);
      check("t1_we_low_cycles", we_low, 2);
      tick();
      check("t1_mem", 32'(mem_a[8'h45]), 32'hA5);

      // port 0 write of 0x3C to 0x10, read back later
      bus_a.addr[0 +: AW] = 19'h00010;
      bus_a.wdata[0 +: DW] = 8'h3C;
      bus_a.wr = 3'b001; bus_a.req = 3'b001;
      exp_addr = 19'h00010; exp_wdata = 8'h3C;
      push_exp(0, 1'b0, 8'h00, cyc + 4);
      wait_ack("pre", 12, 1'b1);
      tick();

      // port 2 read of 0x10
      bus_a.addr[2*AW +: AW] = 19'h00010;
      bus_a.wr = 3'b000; bus_a.req = 3'b100;
      hold_chk = 1'b0; we_low = 0;
      push_exp(2, 1'b1, 8'h3C, cyc + 4);
      wait_ack("t2", 12, 1'b1);
      check("t2_we_low_cycles", we_low, 0);
      tick();
      check("t2_rdata_held", 32'(bus_a.rdata), 32'h3C);

      // port 0 write, req dropped in SETUP
      bus_a.addr[0 +: AW] = 19'h00055;
      bus_a.wdata[0 +: DW] = 8'h99;
      bus_a.wr = 3'b001; bus_a.req = 3'b001;
      exp_addr = 19'h00055; exp_wdata = 8'h99; hold_chk = 1'b1;
      push_exp(0, 1'b0, 8'h00, cyc + 4);
      tick();
      check("t5_setup_grant", 32'(grant_a), 32'd0);
      bus_a.req = 3'b000;
      wait_ack("t5", 12, 1'b0);
      acks = 0; busy_seen = 0;
      tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus_a.ack != 3'b000) acks++;
         if (busy_a) busy_seen++;
      end
      check("t5_no_extra_ack", acks, 0);
      check("t5_no_second_access", busy_seen, 0);
      check("t5_rdata_unchanged", 32'(bus_a.rdata), 32'h3C);
      check("t5_mem", 32'(mem_a[8'h55]), 32'h99);

      // all requests held from reset
      hold_chk = 1'b0;
      rst_a = 1'b1;
      bus_a.addr = {19'h00055, 19'h00010, 19'h00045};
      bus_a.wr = 3'b000; bus_a.req = 3'b111;
      rdv[0] = 8'hA5; rdv[1] = 8'h3C; rdv[2] = 8'h99;
`ifdef SRAM_ARB_VIDEO_PRIO_EN
      ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 1; ord[4] = 2; ord[5] = 1;
`else
      ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0; ord[4] = 1; ord[5] = 2;
`endif
      repeat (2) tick();
      rst_a = 1'b0;
      d = cyc;
      for (int i = 0; i < 6; i++) push_exp(ord[i], 1'b1, rdv[ord[i]], d + 4 + 5*i);
      for (int i = 0; i < 6; i++) begin
         wait_ack("t3", 12, 1'b0);
`ifdef SRAM_ARB_VIDEO_PRIO_EN
         if (i == 2) bus_a.req = 3'b110;
`endif
         if (i == 5) bus_a.req = 3'b000;
      end
      tick();

      // reset during the ACCESS phase of a write
      bus_a.addr[0 +: AW] = 19'h00077;
      bus_a.wdata[0 +: DW] = 8'h11;
      bus_a.wr = 3'b001; bus_a.req = 3'b001;
      tick();
      tick();
      check("t4_in_access_we", 32'(we_a), 32'd0);
      rst_a = 1'b1;
      bus_a.req = 3'b000;
      tick();
      check("t4_we_n", 32'(we_a), 32'd1);
      check("t4_ack", 32'(bus_a.ack), 32'd0);
      check("t4_grant", 32'(grant_a), 32'd3);
      check("t4_busy", 32'(busy_a), 32'd0);
      check("t4_rdata_reset", 32'(bus_a.rdata), 32'd0);
      rst_a = 1'b0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus_a.ack != 3'b000) acks++;
      end
      check("t4_no_ack", acks, 0);

      // WAIT_STATES=0, back-to-back reads on ports 0 and 1
      sel = 1;
      bus_b.addr = {19'h00003, 19'h00002, 19'h00001};
      bus_b.wr = 3'b000; bus_b.req = 3'b011;
      d = cyc;
      push_exp(0, 1'b0, 8'h00, d + 3);
      push_exp(1, 1'b0, 8'h00, d + 7);
      wait_ack("t6a", 10, 1'b1);
      idle_cnt = 0;
      wait_ack("t6b", 10, 1'b1);
      check("t6_idle_gap", idle_cnt, 1);

      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
